// File: rtl/fp_arb_pkg.sv
// rtl/fp_arb_pkg.sv - shared defaults and types for the float unit arbiter
package fp_arb_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_SIZE         = 32;
  localparam int DEF_MAX_INFLIGHT = 8;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] tag_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_unit_arbiter_tag_fifo.sv
// rtl/fp_unit_arbiter_tag_fifo.sv - in-order FIFO of requester tags for issued operations
module tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? bump(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge aclk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/fp_unit_arbiter.sv
// rtl/fp_unit_arbiter.sv - round-robin sharing of one pipelined float unit among requesters
module fp_unit_arbiter #(
  parameter int NUM_REQ      = fp_arb_pkg::DEF_NUM_REQ,
  parameter int SIZE         = fp_arb_pkg::DEF_SIZE,
  parameter int MAX_INFLIGHT = fp_arb_pkg::DEF_MAX_INFLIGHT
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NUM_REQ*SIZE-1:0] req_tdata,
  input  logic [NUM_REQ-1:0]      req_tvalid,
  output logic [NUM_REQ-1:0]      req_tready,
  output logic [SIZE-1:0]         m_axis_a_tdata,
  output logic                    m_axis_a_tvalid,
  input  logic                    m_axis_a_tready,
  input  logic [SIZE-1:0]         s_axis_result_tdata,
  input  logic                    s_axis_result_tvalid,
  output logic                    s_axis_result_tready,
  output logic [NUM_REQ*SIZE-1:0] rsp_tdata,
  output logic [NUM_REQ-1:0]      rsp_tvalid,
  input  logic [NUM_REQ-1:0]      rsp_tready,
  output logic                    err_orphan
);

  import fp_arb_pkg::*;

  localparam int TAG_W = tag_width(NUM_REQ);

  arb_state_e       state_q, state_d;
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0] lock_idx_q, lock_idx_d;
  logic             err_orphan_q, err_orphan_d;

  logic [TAG_W-1:0] grant_idx;
  logic             grant_vld;
  logic [TAG_W-1:0] head_tag;
  logic             head_ready;
  logic             fifo_full, fifo_empty;
  logic             issue, res_hs, pop, orphan;

  // A stalled grant stays put; otherwise search upward from rr_ptr, then wrap below it.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = lock_idx_q;
    if (state_q == ARB_LOCKED) begin
      grant_vld = 1'b1;
    end else if (!fifo_full) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld && req_tvalid[i] && (TAG_W'(i) >= rr_ptr_q)) begin
          grant_vld = 1'b1;
          grant_idx = TAG_W'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld && req_tvalid[i] && (TAG_W'(i) < rr_ptr_q)) begin
          grant_vld = 1'b1;
          grant_idx = TAG_W'(i);
        end
      end
    end
  end

  always_comb begin
    m_axis_a_tdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == TAG_W'(i)) begin
        m_axis_a_tdata = req_tdata[i*SIZE +: SIZE];
      end
    end
  end

  assign m_axis_a_tvalid = aresetn & grant_vld;
  assign issue           = m_axis_a_tvalid & m_axis_a_tready;

  always_comb begin
    req_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tready[i] = issue & (grant_idx == TAG_W'(i));
    end
  end

  // Results come back in issue order, so the FIFO head names the owner.
  always_comb begin
    head_ready = 1'b0;
    rsp_tvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head_tag == TAG_W'(i)) begin
        head_ready    = rsp_tready[i];
        rsp_tvalid[i] = aresetn & ~fifo_empty & s_axis_result_tvalid;
      end
    end
  end

  assign s_axis_result_tready = aresetn & (fifo_empty | head_ready);
  assign res_hs               = s_axis_result_tvalid & s_axis_result_tready;
  assign pop                  = res_hs & ~fifo_empty;
  assign orphan               = res_hs & fifo_empty;
  assign rsp_tdata            = {NUM_REQ{s_axis_result_tdata}};
  assign err_orphan           = err_orphan_q;

  always_comb begin
    state_d      = (m_axis_a_tvalid && !m_axis_a_tready) ? ARB_LOCKED : ARB_OPEN;
    lock_idx_d   = grant_idx;
    rr_ptr_d     = rr_ptr_q;
    err_orphan_d = err_orphan_q | orphan;
    if (issue) begin
      rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= ARB_OPEN;
      lock_idx_q   <= '0;
      rr_ptr_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_idx_q   <= lock_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push_i  (issue),
    .pop_i   (pop),
    .din_i   (grant_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_tag)
  );

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb/tb_fp_unit_arbiter.sv - scoreboard bench for fp_unit_arbiter with a queue-based reference model
module tb_fp_unit_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int M = 8;

  bit               aclk;
  logic             aresetn;
  logic [N*W-1:0]   req_tdata;
  logic [N-1:0]     req_tvalid, req_tready;
  logic [W-1:0]     m_axis_a_tdata;
  logic             m_axis_a_tvalid, m_axis_a_tready;
  logic [W-1:0]     s_axis_result_tdata;
  logic             s_axis_result_tvalid, s_axis_result_tready;
  logic [N*W-1:0]   rsp_tdata;
  logic [N-1:0]     rsp_tvalid, rsp_tready;
  logic             err_orphan;

  fp_unit_arbiter #(.NUM_REQ(N), .SIZE(W), .MAX_INFLIGHT(M)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .req_tdata            (req_tdata),
    .req_tvalid           (req_tvalid),
    .req_tready           (req_tready),
    .m_axis_a_tdata       (m_axis_a_tdata),
    .m_axis_a_tvalid      (m_axis_a_tvalid),
    .m_axis_a_tready      (m_axis_a_tready),
    .s_axis_result_tdata  (s_axis_result_tdata),
    .s_axis_result_tvalid (s_axis_result_tvalid),
    .s_axis_result_tready (s_axis_result_tready),
    .rsp_tdata            (rsp_tdata),
    .rsp_tvalid           (rsp_tvalid),
    .rsp_tready           (rsp_tready),
    .err_orphan           (err_orphan)
  );

  initial forever #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit           avalid;
    logic [W-1:0] adata;
    logic [N-1:0] rdy;
    bit           sready;
    logic [N-1:0] rvalid;
    bit           err;
  } cyc_t;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } txn_t;

  cyc_t     cq[$];
  txn_t     iq[$];
  txn_t     rq[$];
  int       issue_log[$];

  // Reference state: outstanding requester ids in issue order, pointer, lock, sticky error.
  int       tags[$];
  int       rr = 0;
  bit       lk = 0;
  int       lk_idx = 0;
  bit       err_m = 0;
  bit [N-1:0] acc_vec = '0;
  bit       s_acc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge aclk) begin : model
    cyc_t e;
    int   g;
    int   h;
    e.avalid = 0; e.adata = '0; e.rdy = '0; e.sready = 0; e.rvalid = '0;
    g = -1;
    h = (tags.size() > 0) ? tags[0] : -1;
    acc_vec = '0;
    s_acc = 0;
    if (aresetn) begin
      if (lk) g = lk_idx;
      else if (tags.size() < M) begin
        for (int k = 0; k < N; k++) if (g < 0 && req_tvalid[(rr + k) % N]) g = (rr + k) % N;
      end
      if (g >= 0) begin
        e.avalid = 1;
        e.adata  = req_tdata[g*W +: W];
        if (m_axis_a_tready) e.rdy[g] = 1'b1;
      end
      e.sready = (h < 0) ? 1'b1 : rsp_tready[h];
      if (h >= 0 && s_axis_result_tvalid) e.rvalid[h] = 1'b1;
    end
    e.err = err_m;
    cq.push_back(e);
    if (!aresetn) begin
      rr = 0; lk = 0; err_m = 0;
      tags.delete();
    end else begin
      if (s_axis_result_tvalid && e.sready) begin
        s_acc = 1;
        if (h < 0) err_m = 1;
        else begin
          rq.push_back('{idx: h, data: s_axis_result_tdata});
          void'(tags.pop_front());
        end
      end
      if (g >= 0 && m_axis_a_tready) begin
        iq.push_back('{idx: g, data: e.adata});
        tags.push_back(g);
        rr = (g + 1) % N;
        lk = 0;
        acc_vec[g] = 1'b1;
      end else if (g >= 0) begin
        lk = 1; lk_idx = g;
      end
    end
  end

  always @(negedge aclk) begin : monitor
    cyc_t e;
    txn_t t;
    #2;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      chk("a_tvalid", m_axis_a_tvalid, e.avalid);
      if (e.avalid) chk("a_tdata", m_axis_a_tdata, e.adata);
      chk("req_tready", req_tready, e.rdy);
      chk("s_tready", s_axis_result_tready, e.sready);
      chk("rsp_tvalid", rsp_tvalid, e.rvalid);
      chk("err_orphan", err_orphan, e.err);
    end
    if (m_axis_a_tvalid && m_axis_a_tready) begin
      issue_log.push_back(oh_idx(req_tready));
      if (iq.size() == 0) begin
        tests++; fails++;
        $display("FAIL issue_unexpected: DUT issued for req %0d, none expected", oh_idx(req_tready));
      end else begin
        t = iq.pop_front();
        chk("issue_idx", oh_idx(req_tready), t.idx);
        chk("issue_data", m_axis_a_tdata, t.data);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rsp_tvalid[i] && rsp_tready[i]) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp_unexpected: DUT returned on port %0d, none expected", i);
        end else begin
          t = rq.pop_front();
          chk("rsp_port", i, t.idx);
          chk("rsp_data", rsp_tdata[i*W +: W], t.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic sample();
    @(negedge aclk);
    #3;
  endtask

  task automatic do_reset();
    aresetn = 0; req_tvalid = '0; m_axis_a_tready = 0;
    s_axis_result_tvalid = 0; rsp_tready = '0;
    repeat (2) cyc();
    aresetn = 1;
  endtask

  task automatic drain(input int n);
    req_tvalid = '0; rsp_tready = '1;
    repeat (n) begin
      s_axis_result_tvalid = (tags.size() > 0);
      s_axis_result_tdata  = $urandom;
      cyc();
    end
    s_axis_result_tvalid = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    req_tdata = '0; s_axis_result_tdata = '0;
    do_reset();

    // All requesters valid, unit always ready: strict 0,1,2,3 rotation.
    issue_log.delete();
    req_tvalid = '1; m_axis_a_tready = 1; rsp_tready = '1;
    repeat (12) begin
      for (int i = 0; i < N; i++) req_tdata[i*W +: W] = $urandom;
      s_axis_result_tvalid = (tags.size() > 0);
      s_axis_result_tdata  = $urandom;
      cyc();
    end
    sample();
    chk("order_count", issue_log.size() >= 8, 1);
    for (int k = 0; k < 8; k++) if (k < issue_log.size()) chk("rr_order", issue_log[k], k % 4);
    cyc();
    drain(12);

    // Grant lock while the unit stalls.
    do_reset();
    rsp_tready = '1;
    req_tdata[2*W +: W] = 32'h40490FDB; req_tvalid = 4'b0100; m_axis_a_tready = 0;
    sample(); chk("lock_tdata0", m_axis_a_tdata, 32'h40490FDB); chk("lock_tvalid", m_axis_a_tvalid, 1);
    cyc();
    req_tdata[0 +: W] = $urandom; req_tvalid[0] = 1;
    sample(); chk("lock_tdata1", m_axis_a_tdata, 32'h40490FDB); chk("lock_tready1", req_tready, 0);
    cyc();
    sample(); chk("lock_tdata2", m_axis_a_tdata, 32'h40490FDB);
    cyc();
    m_axis_a_tready = 1;
    sample(); chk("lock_accept", req_tready, 4'b0100);
    cyc();
    req_tvalid[2] = 0;
    sample(); chk("after_lock", req_tready, 4'b0001);
    cyc();
    drain(8);

    // Fill to MAX_INFLIGHT, then one pop; issue resumes only the cycle after.
    do_reset();
    req_tvalid = '1; m_axis_a_tready = 1; rsp_tready = '1;
    repeat (8) cyc();
    repeat (2) begin
      sample(); chk("full_tready", req_tready, 0); chk("full_tvalid", m_axis_a_tvalid, 0);
      cyc();
    end
    s_axis_result_tvalid = 1; s_axis_result_tdata = $urandom;
    sample(); chk("pop_sready", s_axis_result_tready, 1); chk("pop_blocks_issue", req_tready, 0);
    cyc();
    s_axis_result_tvalid = 0;
    sample(); chk("resume_issue", req_tready, 4'b0001);
    cyc();
    drain(12);

    // Head owner stalls its response port.
    do_reset();
    req_tvalid = 4'b0010; m_axis_a_tready = 1;
    cyc();
    req_tvalid = '0; s_axis_result_tvalid = 1; s_axis_result_tdata = 32'h3F800000; rsp_tready = 4'b1101;
    repeat (5) begin
      sample(); chk("hold_sready", s_axis_result_tready, 0); chk("hold_rvalid", rsp_tvalid, 4'b0010);
      cyc();
    end
    rsp_tready = '1;
    sample(); chk("release_sready", s_axis_result_tready, 1);
    cyc();
    s_axis_result_tvalid = 0;
    sample(); chk("popped_rvalid", rsp_tvalid, 0); chk("no_orphan", err_orphan, 0);
    cyc();

    // Orphan result: sticky until reset.
    do_reset();
    s_axis_result_tvalid = 1; s_axis_result_tdata = $urandom;
    sample(); chk("drain_sready", s_axis_result_tready, 1); chk("orphan_pre", err_orphan, 0);
    cyc();
    s_axis_result_tvalid = 0;
    sample(); chk("orphan_set", err_orphan, 1);
    cyc();
    repeat (3) cyc();
    sample(); chk("orphan_held", err_orphan, 1);
    cyc();
    aresetn = 0;
    sample(); chk("orphan_until_edge", err_orphan, 1);
    cyc();
    sample(); chk("orphan_cleared", err_orphan, 0);
    cyc();
    aresetn = 1;

    // Reset with three outstanding discards them and rewinds rr_ptr.
    do_reset();
    req_tvalid = '1; m_axis_a_tready = 1; rsp_tready = '1;
    repeat (3) cyc();
    aresetn = 0; s_axis_result_tvalid = 1; s_axis_result_tdata = $urandom;
    sample(); chk("rst_rvalid", rsp_tvalid, 0); chk("rst_tready", req_tready, 0);
    chk("rst_tvalid", m_axis_a_tvalid, 0); chk("rst_sready", s_axis_result_tready, 0);
    cyc();
    aresetn = 1;
    sample(); chk("post_rst_rvalid", rsp_tvalid, 0); chk("post_rst_rr", req_tready, 4'b0001);
    cyc();
    s_axis_result_tvalid = 0; req_tvalid = '0;
    sample(); chk("post_rst_orphan", err_orphan, 1);
    cyc();

    // Randomized traffic with occasional mid-operation resets.
    do_reset();
    repeat (2000) begin
      aresetn = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_tvalid[i] || acc_vec[i]) begin
          req_tvalid[i] = ($urandom_range(0, 2) != 0);
          req_tdata[i*W +: W] = $urandom;
        end
      end
      m_axis_a_tready = ($urandom_range(0, 3) != 0);
      rsp_tready = N'($urandom);
      if (!s_axis_result_tvalid || s_acc) begin
        s_axis_result_tvalid = (tags.size() > 0) && ($urandom_range(0, 1) == 1);
        s_axis_result_tdata  = $urandom;
      end
      cyc();
    end
    aresetn = 1;
    drain(30);
    sample();
    chk("issue_queue_empty", iq.size(), 0);
    chk("rsp_queue_empty", rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_unit_arbiter.md
FP_UNIT_ARBITER -- requirements
Module: fp_unit_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  NUM_REQ, 4, number of requesters (2..8)
  SIZE, 32, data width in bits
  MAX_INFLIGHT, 8, maximum operations issued but not yet returned (power of 2)
REQ-002 Ports SHALL be, one per line:
  aclk  in  1  clock
  aresetn  in  1  reset; synchronous, active-low
  req_tdata  in  NUM_REQ x SIZE  requester operands
  req_tvalid  in  NUM_REQ  requester valid
  req_tready  out  NUM_REQ  requester ready
  m_axis_a_tdata  out  SIZE  operand to shared float unit
  m_axis_a_tvalid  out  1  operand valid
  m_axis_a_tready  in  1  unit ready
  s_axis_result_tdata  in  SIZE  unit result
  s_axis_result_tvalid  in  1  result valid
  s_axis_result_tready  out  1  result ready
  rsp_tdata  out  NUM_REQ x SIZE  per-requester result
  rsp_tvalid  out  NUM_REQ  per-requester result valid
  rsp_tready  in  NUM_REQ  per-requester result ready
  err_orphan  out  1  sticky: result arrived with no operation outstanding

Function
REQ-003 Issue eligibility SHALL be: req_tvalid[i] high and outstanding count < MAX_INFLIGHT; a full count blocks issue even when a pop occurs in the same cycle.
REQ-004 Grant SHALL be round-robin: search starts at rr_ptr; after an accepted issue from i, rr_ptr becomes (i+1) mod NUM_REQ; with no issue, rr_ptr is unchanged.
REQ-005 While m_axis_a_tvalid is high and m_axis_a_tready is low, the grant SHALL be locked: same requester, same data, no re-arbitration.
REQ-006 m_axis_a_tdata SHALL equal req_tdata[granted]; m_axis_a_tvalid SHALL be high iff a grant exists; req_tready[i] SHALL equal (granted==i) & m_axis_a_tready.
REQ-007 Each issue handshake SHALL push the requester index into an in-order tag FIFO of depth MAX_INFLIGHT and increment the count.
REQ-008 Results SHALL route to the requester at the FIFO head: rsp_tvalid[head] = s_axis_result_tvalid; all other rsp_tvalid are 0; every rsp_tdata equals s_axis_result_tdata.
REQ-009 s_axis_result_tready SHALL equal rsp_tready[head] when the FIFO is non-empty, and 1 when it is empty (drain).
REQ-010 A result handshake SHALL pop the FIFO and decrement the count; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-011 A result handshake with the FIFO empty SHALL set err_orphan, which SHALL hold until reset; the FIFO and count SHALL be unchanged.
REQ-012 Arbitration path latency SHALL be 0 cycles (combinational grant); the FIFO/count update SHALL take effect on the next aclk edge.
REQ-013 FIFO pointers SHALL wrap modulo MAX_INFLIGHT.

Reset
REQ-014 With aresetn low at posedge aclk: count=0, FIFO pointers=0, rr_ptr=0, grant lock cleared, err_orphan=0.
REQ-015 While aresetn is low, req_tready, m_axis_a_tvalid, rsp_tvalid and s_axis_result_tready SHALL all be 0.
REQ-016 Reset mid-operation SHALL discard all outstanding tags; results arriving after reset with the FIFO empty SHALL set err_orphan.

Structure
REQ-017 Package fp_arb_pkg SHALL hold NUM_REQ, SIZE, MAX_INFLIGHT defaults and tag_t (logic [$clog2(NUM_REQ)-1:0]).
REQ-018 The tag FIFO SHALL be a sub-module, tag_fifo (depth, width parameters; push/pop/full/empty/head).

Verification
REQ-019 Bench SHALL cover:
  - All 4 requesters valid continuously, unit always ready -> issue order 0,1,2,3,0,...; results returned to matching rsp ports.
  - Requester 2 valid with data 0x40490FDB, m_axis_a_tready low 3 cycles, requester 0 then asserts -> tdata stays 0x40490FDB and the grant stays on 2 until accepted.
  - 8 issues with no results -> count=8, all req_tready 0; one result then pops -> issue resumes the following cycle.
  - Result valid at head=1 with rsp_tready[1] low 5 cycles -> s_axis_result_tready low, no pop; pops on the cycle rsp_tready[1] rises.
  - Result valid with FIFO empty -> err_orphan=1 next cycle and held; cleared only by aresetn=0.
  - Reset asserted with 3 outstanding -> count=0, all rsp_tvalid 0, rr_ptr=0 after reset.
